apple_stim_gen: RTL and testbench

Self-checking operand generator for the `apple` registered-AND stage. It drives `a`/`b` into `apple` with an exhaustive pass over all four input combinations, then a configurable LFSR-driven random pass. It compares `apple`'s `q` against a one-cycle-delayed golden model and counts mismatches. It sits directly upstream of `apple` and closes the loop on its output.

---
 rtl/apple_pkg.sv | 23 ++
 rtl/apple_lfsr16.sv | 32 +++
 rtl/apple_stim_gen.sv | 149 ++++++++++++++
 tb/tb_apple_stim_gen.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/apple_pkg.sv
// Shared types and constants for the apple operand generator.
// Holds the run-state enum, LFSR taps and the exhaustive-pass length.
package apple_pkg;

  typedef enum logic [1:0] {
    IDLE,
    EXH,
    RND,
    DRAIN
  } stim_state_t;

  localparam logic [15:0] LFSR_TAPS   = 16'hB400;
  localparam int unsigned EXH_VECTORS = 4;

  // Galois right-shift step
  function automatic logic [15:0] lfsr_next(
    input logic [15:0] s
  );
    lfsr_next = {1'b0, s[15:1]}
              ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/apple_lfsr16.sv
// 16-bit Galois LFSR with synchronous load and advance enable.
// Ports: clk, rst, load_i, en_i, seed_i[15:0] -> state_o[15:0].
module apple_lfsr16
  import apple_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        en_i,
  input  logic [15:0] seed_i,
  output logic [15:0] state_o
);

  logic [15:0] state_q;
  logic [15:0] seed_eff;

  // all-zero is a lock-up state for the LFSR
  assign seed_eff = (seed_i == 16'h0000) ? 16'h0001 : seed_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= seed_eff;
    end else if (load_i) begin
      state_q <= seed_eff;
    end else if (en_i) begin
      state_q <= lfsr_next(state_q);
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/apple_stim_gen.sv
// Operand generator and checker for the registered-AND apple stage.
// Ports: clk, rst, start, rand_len -> a, b, op_valid; q_in checked
// against exp_q when exp_valid; busy, done, miss_cnt, err report.
module apple_stim_gen
  import apple_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int          MISS_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [15:0]       rand_len,
  output logic              a,
  output logic              b,
  output logic              op_valid,
  input  logic              q_in,
  output logic              exp_valid,
  output logic              exp_q,
  output logic              busy,
  output logic              done,
  output logic [MISS_W-1:0] miss_cnt,
  output logic              err
);

  localparam logic [1:0] EXH_LAST = 2'(EXH_VECTORS - 1);

  stim_state_t       state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [1:0]        idx_q, idx_d;
  logic              a_q, a_d;
  logic              b_q, b_d;
  logic              ov_q, ov_d;
  logic              done_q, done_d;
  logic              ev_q, eq_q;
  logic [MISS_W-1:0] miss_q, miss_d;
  logic              err_q, err_d;
  logic              lfsr_ld, lfsr_en;
  logic              accept;
  logic [15:0]       lfsr_s;
  logic              lfsr_unused;

  apple_lfsr16 u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .load_i (lfsr_ld),
    .en_i   (lfsr_en),
    .seed_i (LFSR_SEED),
    .state_o(lfsr_s)
  );

  assign lfsr_unused = ^lfsr_s[15:2];
  assign accept = (state_q == IDLE) && start;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    a_d     = 1'b0;
    b_d     = 1'b0;
    ov_d    = 1'b0;
    done_d  = 1'b0;
    lfsr_ld = 1'b0;
    lfsr_en = 1'b0;
    miss_d  = miss_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = EXH;
          idx_d   = 2'd0;
          cnt_d   = rand_len;
          ov_d    = 1'b1;
          lfsr_ld = 1'b1;
        end
      end
      EXH, RND: begin
        if (state_q == EXH && idx_q != EXH_LAST) begin
          idx_d      = idx_q + 2'd1;
          {a_d, b_d} = idx_q + 2'd1;
          ov_d       = 1'b1;
        end else if (cnt_q != 16'd0) begin
          // cnt_q counts random vectors still to issue
          state_d = RND;
          a_d     = lfsr_s[0];
          b_d     = lfsr_s[1];
          ov_d    = 1'b1;
          lfsr_en = 1'b1;
          cnt_d   = cnt_q - 16'd1;
        end else begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      miss_d = '0;
      err_d  = 1'b0;
    end else if (ev_q && (q_in != eq_q)) begin
      err_d = 1'b1;
      if (miss_q != '1) begin
        miss_d = miss_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      ov_q    <= 1'b0;
      done_q  <= 1'b0;
      ev_q    <= 1'b0;
      eq_q    <= 1'b0;
      miss_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ov_q    <= ov_d;
      done_q  <= done_d;
      ev_q    <= ov_q;
      eq_q    <= a_q & b_q;
      miss_q  <= miss_d;
      err_q   <= err_d;
    end
  end

  assign a         = a_q;
  assign b         = b_q;
  assign op_valid  = ov_q;
  assign exp_valid = ev_q;
  assign exp_q     = eq_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign miss_cnt  = miss_q;
  assign err       = err_q;

endmodule

// File: tb/tb_apple_stim_gen.sv
// Bench for apple_stim_gen: table runs, corner sequences, random runs.
// q_in is sourced from a behavioural apple or a fault-injecting mode.
module tb_apple_stim_gen;

  localparam int M_APPLE = 0;
  localparam int M_ZERO  = 1;
  localparam int M_INV   = 2;
  localparam int M_RAND  = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] rand_len = '0;
  logic        q_in;
  logic        a, b, op_valid, exp_valid, exp_q;
  logic        busy, done, err;
  logic [7:0]  miss_cnt;

  int   mode = M_APPLE;
  logic apple_q = 1'b0;
  logic rnd_q = 1'b0;
  int   total = 0;
  int   bad = 0;
  logic got_a [0:511];
  logic got_b [0:511];

  typedef struct {
    int   len;
    int   m;
    int   miss;
    logic err;
  } vec_t;
  vec_t tbl [5];

  apple_stim_gen #(
    .LFSR_SEED(16'hACE1),
    .MISS_W   (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .rand_len (rand_len),
    .a        (a),
    .b        (b),
    .op_valid (op_valid),
    .q_in     (q_in),
    .exp_valid(exp_valid),
    .exp_q    (exp_q),
    .busy     (busy),
    .done     (done),
    .miss_cnt (miss_cnt),
    .err      (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) apple_q <= a & b;

  always_comb begin
    q_in = rnd_q;
    case (mode)
      M_APPLE: q_in = apple_q;
      M_ZERO:  q_in = 1'b0;
      M_INV:   q_in = ~exp_q;
      default: q_in = rnd_q;
    endcase
  end

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  task automatic reset_chk(input string nm);
    chk({nm, "_a"}, a, 0);
    chk({nm, "_b"}, b, 0);
    chk({nm, "_opv"}, op_valid, 0);
    chk({nm, "_expv"}, exp_valid, 0);
    chk({nm, "_expq"}, exp_q, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_miss"}, miss_cnt, 0);
    chk({nm, "_err"}, err, 0);
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    logic [15:0] n;
    n = s >> 1;
    if (s[0]) n = n ^ 16'hB400;
    return n;
  endfunction

  // Full run from start to done, checking every cycle.
  task automatic do_run(input int len, input int m,
                        input int restart_at);
    logic        ea[$];
    logic        eb[$];
    logic [15:0] s;
    int          miss;
    int          last;
    logic        e;
    mode = m;
    for (int k = 0; k < 4; k++) begin
      ea.push_back(k[1]);
      eb.push_back(k[0]);
    end
    s = 16'hACE1;
    for (int i = 0; i < len; i++) begin
      ea.push_back(s[0]);
      eb.push_back(s[1]);
      s = lfsr_step(s);
    end
    miss = 0;
    last = 6 + len;
    @(negedge clk);
    start = 1'b1;
    rand_len = len[15:0];
    @(posedge clk);
    #1;
    start = 1'b0;
    rand_len = 16'($urandom);
    for (int c = 1; c <= last; c++) begin
      rnd_q = 1'($urandom_range(0, 1));
      @(negedge clk);
      got_a[c] = a;
      got_b[c] = b;
      chk("op_valid", op_valid, 32'(c <= 4 + len));
      if (c <= 4 + len) begin
        chk("a", a, ea[c-1]);
        chk("b", b, eb[c-1]);
      end
      chk("exp_valid", exp_valid, 32'(c >= 2 && c <= 5 + len));
      if (c >= 2 && c <= 5 + len) begin
        e = ea[c-2] & eb[c-2];
        chk("exp_q", exp_q, e);
        if (q_in !== e && miss < 255) miss++;
      end
      chk("busy", busy, 32'(c <= 5 + len));
      chk("done", done, 32'(c == last));
      if (c == restart_at) begin
        start = 1'b1;
        rand_len = 16'd100;
      end
      if (c < last) begin
        @(posedge clk);
        #1;
        start = 1'b0;
      end
    end
    chk("miss_cnt", miss_cnt, miss);
    chk("err", err, 32'(miss > 0));
  endtask

  initial begin
    tbl[0] = '{len: 0,   m: M_APPLE, miss: 0,   err: 1'b0};
    tbl[1] = '{len: 0,   m: M_ZERO,  miss: 1,   err: 1'b1};
    tbl[2] = '{len: 3,   m: M_APPLE, miss: 0,   err: 1'b0};
    tbl[3] = '{len: 300, m: M_INV,   miss: 255, err: 1'b1};
    tbl[4] = '{len: 0,   m: M_INV,   miss: 4,   err: 1'b1};

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_chk("reset");
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      do_run(tbl[i].len, tbl[i].m, -1);
      chk("tbl_miss", miss_cnt, tbl[i].miss);
      chk("tbl_err", err, tbl[i].err);
    end

    // explicit random vectors from seed ACE1
    do_run(3, M_APPLE, -1);
    chk("rv0_a", got_a[5], 1);
    chk("rv0_b", got_b[5], 0);
    chk("rv1_a", got_a[6], 0);
    chk("rv1_b", got_b[6], 0);
    chk("rv2_a", got_a[7], 0);
    chk("rv2_b", got_b[7], 0);

    // start while busy is ignored
    do_run(5, M_APPLE, 3);

    // reset mid-run
    mode = M_INV;
    @(negedge clk);
    start = 1'b1;
    rand_len = 16'd10;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_miss", miss_cnt, 1);
    rst = 1'b1;
    @(negedge clk);
    reset_chk("midrst");
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("post_rst_done", done, 0);
      chk("post_rst_busy", busy, 0);
    end
    do_run(2, M_APPLE, -1);

    for (int r = 0; r < 6; r++) begin
      do_run(int'($urandom_range(0, 40)),
             int'($urandom_range(0, 3)), -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
